// File: rtl/voice_allocator.sv
// voice_allocator: assigns keyboard note events to a bank of envelope voices.
// Optional VOICE_STEAL_EN: steal the oldest voice when all are gated.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6,
  parameter int AGE_W      = 8,
  parameter int RETRIG_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  input  logic [NUM_VOICES-1:0]       voice_idle,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic                        drop,
  output logic [3:0]                  active_cnt
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

`ifdef VOICE_STEAL_EN
  typedef enum logic [1:0] {
    IDLE, SEARCH, APPLY, STEAL_LOW
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, SEARCH, APPLY
  } state_t;
`endif

  typedef enum logic [1:0] {
    A_NONE, A_ON, A_OFF, A_DROP
  } act_t;

  state_t state, state_d;
  act_t   act_q, act_d;

  logic             rdy_q;
  logic             ev_on_q;
  logic [KEY_W-1:0] ev_key_q;
  logic [IW-1:0]    sel_q, sel_d;

  logic [NUM_VOICES-1:0] gate_d;
  logic [3:0]            pop_d;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];

  logic          dup, free_f, rel_f;
  logic [IW-1:0] dup_i, free_i, rel_i;

  assign ev_ready = rdy_q && (state == IDLE);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key
    assign voice_key[g*KEY_W +: KEY_W] = key_q[g];
  end

  // Descending scan so the lowest index overwrites last.
  always_comb begin
    dup    = 1'b0;
    free_f = 1'b0;
    rel_f  = 1'b0;
    dup_i  = '0;
    free_i = '0;
    rel_i  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_gate[i] && key_q[i] == ev_key_q) begin
        dup   = 1'b1;
        dup_i = IW'(i);
      end
      if (!voice_gate[i] && voice_idle[i]) begin
        free_f = 1'b1;
        free_i = IW'(i);
      end
      if (!voice_gate[i] && !voice_idle[i]) begin
        rel_f = 1'b1;
        rel_i = IW'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IW-1:0]    old_i;
  logic [AGE_W-1:0] old_a;
  logic             steal_d;
  logic [15:0]      retrig_q;

  localparam logic [15:0] RETRIG_LD =
    (RETRIG_CYC == 0) ? 16'd1 : 16'(RETRIG_CYC);

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    old_i = '0;
    old_a = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_a) begin
        old_a = age_q[i];
        old_i = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retrig_q <= '0;
    end else if (state == SEARCH) begin
      retrig_q <= RETRIG_LD;
    end else if (state == STEAL_LOW) begin
      retrig_q <= retrig_q - 16'd1;
    end
  end
`endif

  always_comb begin
    act_d = A_NONE;
    sel_d = '0;
`ifdef VOICE_STEAL_EN
    steal_d = 1'b0;
`endif
    if (!ev_on_q) begin
      if (dup) begin
        act_d = A_OFF;
        sel_d = dup_i;
      end
    end else if (dup) begin
      act_d = A_NONE;
    end else if (free_f) begin
      act_d = A_ON;
      sel_d = free_i;
    end else if (rel_f) begin
      act_d = A_ON;
      sel_d = rel_i;
    end else begin
`ifdef VOICE_STEAL_EN
      act_d   = A_ON;
      sel_d   = old_i;
      steal_d = 1'b1;
`else
      act_d = A_DROP;
`endif
    end
  end

  always_comb begin
    state_d = state;
    gate_d  = voice_gate;
    case (state)
      IDLE: begin
        if (ev_valid && ev_ready) state_d = SEARCH;
      end
      SEARCH: begin
        state_d = APPLY;
`ifdef VOICE_STEAL_EN
        if (steal_d) begin
          state_d       = STEAL_LOW;
          gate_d[sel_d] = 1'b0;
        end
`endif
      end
`ifdef VOICE_STEAL_EN
      STEAL_LOW: begin
        if (retrig_q == 16'd1) state_d = APPLY;
      end
`endif
      APPLY: begin
        state_d = IDLE;
        if (act_q == A_ON) gate_d[sel_q] = 1'b1;
        else if (act_q == A_OFF) gate_d[sel_q] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      pop_d = pop_d + 4'(gate_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_key_q   <= '0;
      act_q      <= A_NONE;
      sel_q      <= '0;
      voice_gate <= '0;
      active_cnt <= '0;
      drop       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      state      <= state_d;
      rdy_q      <= 1'b1;
      voice_gate <= gate_d;
      active_cnt <= pop_d;
      drop       <= (state == SEARCH) && (act_d == A_DROP);
      if (ev_valid && ev_ready) begin
        ev_on_q  <= ev_on;
        ev_key_q <= ev_key;
      end
      if (state == SEARCH) begin
        act_q <= act_d;
        sel_q <= sel_d;
      end
      if (state == APPLY && act_q == A_ON) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == sel_q) begin
            key_q[i] <= ev_key_q;
            age_q[i] <= '0;
          end else if (voice_gate[i] && age_q[i] != AGE_MAX) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and random note events checked
// against an event-level model of voice assignment.
`timescale 1ns/1ps
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int KW = 6;
  localparam int R  = 50000;

  localparam int K_NONE  = 0;
  localparam int K_ON    = 1;
  localparam int K_OFF   = 2;
  localparam int K_STEAL = 3;
  localparam int K_DROP  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [KW-1:0] ev_key = '0;
  logic [NV-1:0] voice_idle = '1;
  logic          ev_ready;
  logic          drop;
  logic [NV-1:0] voice_gate;
  logic [NV*KW-1:0] voice_key;
  logic [3:0]    active_cnt;

  int tests = 0;
  int fails = 0;

  bit            mg [NV];
  logic [KW-1:0] mk [NV];
  int            ma [NV];

  voice_allocator #(
    .NUM_VOICES(NV),
    .KEY_W(KW),
    .AGE_W(8),
    .RETRIG_CYC(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_on(ev_on),
    .ev_key(ev_key),
    .voice_idle(voice_idle),
    .voice_gate(voice_gate),
    .voice_key(voice_key),
    .drop(drop),
    .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV-1:0] exp_gate();
    logic [NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = mg[i];
    return v;
  endfunction

  function automatic logic [NV*KW-1:0] exp_keys();
    logic [NV*KW-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*KW +: KW] = mk[i];
    return v;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NV; i++) n += int'(mg[i]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      mg[i] = 1'b0;
      mk[i] = '0;
      ma[i] = 0;
    end
  endfunction

  // Rule list: duplicate, free, releasing, then steal/drop.
  function automatic void pick(input bit on, input logic [KW-1:0] k,
                               output int kind, output int idx);
    int best;
    kind = K_NONE;
    idx  = 0;
    for (int i = 0; i < NV; i++) begin
      if (mg[i] && mk[i] == k) begin
        kind = on ? K_NONE : K_OFF;
        idx  = i;
        return;
      end
    end
    if (!on) return;
    for (int i = 0; i < NV; i++) begin
      if (!mg[i] && voice_idle[i]) begin
        kind = K_ON;
        idx  = i;
        return;
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (!mg[i] && !voice_idle[i]) begin
        kind = K_ON;
        idx  = i;
        return;
      end
    end
`ifdef VOICE_STEAL_EN
    best = -1;
    for (int i = 0; i < NV; i++) begin
      if (ma[i] > best) begin
        best = ma[i];
        idx  = i;
      end
    end
    kind = K_STEAL;
`else
    best = 0;
    kind = K_DROP + best;
`endif
  endfunction

  function automatic void model_apply(input int kind, input int idx,
                                      input logic [KW-1:0] k);
    if (kind == K_ON || kind == K_STEAL) begin
      for (int i = 0; i < NV; i++) begin
        if (i != idx && mg[i]) ma[i] = (ma[i] >= 255) ? 255 : ma[i] + 1;
      end
      mk[idx] = k;
      mg[idx] = 1'b1;
      ma[idx] = 0;
    end else if (kind == K_OFF) begin
      mg[idx] = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_gate"}, 32'(voice_gate), 32'(exp_gate()));
    chk({tag, "_keys"}, 32'(voice_key), 32'(exp_keys()));
    chk({tag, "_cnt"}, 32'(active_cnt), 32'(exp_cnt()));
  endtask

  task automatic send(input bit on, input logic [KW-1:0] k,
                      input string tag);
    int kind, idx, t, low;
    pick(on, k, kind, idx);
    t = 0;
    while (!ev_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rdy_wait"}, 32'(ev_ready), 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = k;
    @(negedge clk);
    ev_valid = 1'b0;
    chk({tag, "_busy"}, 32'(ev_ready), 32'd0);
    chk({tag, "_hold"}, 32'(voice_gate), 32'(exp_gate()));
    if (kind == K_STEAL) begin
      low = 0;
      do begin
        @(negedge clk);
        if (!voice_gate[idx]) low++;
      end while (!voice_gate[idx] && low < R + 20);
      chk({tag, "_low_cyc"}, 32'(low), 32'(R + 1));
    end else begin
      @(negedge clk);
      chk({tag, "_drop"}, 32'(drop), 32'(kind == K_DROP));
      chk({tag, "_hold2"}, 32'(voice_gate), 32'(exp_gate()));
      @(negedge clk);
    end
    model_apply(kind, idx, k);
    check_all(tag);
    chk({tag, "_rdy"}, 32'(ev_ready), 32'd1);
    chk({tag, "_drop_end"}, 32'(drop), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    bit            on;
    logic [KW-1:0] k;
    int            kind, idx;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ev_ready), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    check_all("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ev_ready), 32'd1);

    send(1'b1, 6'd10, "on10");
    send(1'b1, 6'd12, "on12");
    chk("t2_gate", 32'(voice_gate), 32'h3);
    chk("t2_cnt", 32'(active_cnt), 32'd2);
    send(1'b1, 6'd10, "dup10");
    send(1'b0, 6'd12, "off12");
    chk("t3_gate", 32'(voice_gate), 32'h1);
    send(1'b0, 6'd40, "off40");

    send(1'b1, 6'd3, "on3");
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_key   = 6'd9;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    ev_valid = 1'b0;
    chk("async_gate", 32'(voice_gate), 32'd0);
    chk("async_keys", 32'(voice_key), 32'd0);
    chk("async_cnt", 32'(active_cnt), 32'd0);
    chk("async_rdy", 32'(ev_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rel_rdy", 32'(ev_ready), 32'd1);

    voice_idle = '1;
    send(1'b1, 6'd20, "f20");
    send(1'b1, 6'd21, "f21");
    send(1'b1, 6'd22, "f22");
    send(1'b0, 6'd20, "o20");
    send(1'b0, 6'd22, "o22");
    voice_idle = 4'b0100;
    send(1'b1, 6'd7, "rel_free");
    chk("t6_v2", 32'(voice_gate), 32'b0110);
    voice_idle = 4'b0000;
    send(1'b1, 6'd8, "rel_reuse");
    chk("t6_v0key", 32'(voice_key[KW-1:0]), 32'd8);

    reset_pulse();
    voice_idle = '1;
    for (int i = 1; i <= 4; i++) send(1'b1, KW'(i), "fill");
    send(1'b1, 6'd5, "full_on5");
`ifdef VOICE_STEAL_EN
    chk("t4_key0", 32'(voice_key[KW-1:0]), 32'd5);
`else
    chk("t5_keys", 32'(voice_key), {8'd0, 6'd4, 6'd3, 6'd2, 6'd1});
`endif
    chk("t45_gate", 32'(voice_gate), 32'hf);

    for (int n = 0; n < 200; n++) begin
      voice_idle = NV'($urandom);
      on = ($urandom_range(0, 9) < 6);
      k  = KW'($urandom_range(0, 7));
      pick(on, k, kind, idx);
      if (kind == K_STEAL) on = 1'b0;
      send(on, k, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
